// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID/EX stage: ALU control codes and forward-select values.
// Used by forward_unit and id_ex_stage (forwarding enabled by FORWARD_EN).
package mips_pkg;

    localparam logic [2:0] ALUADD = 3'b010;
    localparam logic [2:0] ALUSUB = 3'b110;
    localparam logic [2:0] ALUAND = 3'b000;
    localparam logic [2:0] ALUOR  = 3'b001;
    localparam logic [2:0] ALUSLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Forward-source select for one EX operand index. Instantiated per operand when
// id_ex_stage is built with FORWARD_EN.
module forward_unit
    import mips_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] src_i,
    input  logic          mem_regwrite_i,
    input  logic [RW-1:0] mem_writereg_i,
    input  logic          wb_regwrite_i,
    input  logic [RW-1:0] wb_writereg_i,
    output logic [1:0]    sel_o
);

    logic src_nz;
    assign src_nz = (src_i != '0);

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        sel_o = FWD_REG;
        if (src_nz && mem_regwrite_i && (mem_writereg_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (src_nz && wb_regwrite_i && (wb_writereg_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and EX operand selection.
// Define FORWARD_EN to include EX/MEM and MEM/WB forwarding; otherwise operands come from the registers.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_rd1_i,
    input  logic [DW-1:0] id_rd2_i,
    input  logic [DW-1:0] id_signimm_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [RW-1:0] id_rd_i,
    input  logic          id_regwrite_i,
    input  logic          id_memtoreg_i,
    input  logic          id_memwrite_i,
    input  logic          id_alusrc_i,
    input  logic          id_regdst_i,
    input  logic [CW-1:0] id_alucontrol_i,
    input  logic          mem_regwrite_i,
    input  logic [RW-1:0] mem_writereg_i,
    input  logic [DW-1:0] mem_aluout_i,
    input  logic          wb_regwrite_i,
    input  logic [RW-1:0] wb_writereg_i,
    input  logic [DW-1:0] wb_result_i,
    output logic [DW-1:0] ex_srca_o,
    output logic [DW-1:0] ex_srcb_o,
    output logic [CW-1:0] ex_alucontrol_o,
    output logic [DW-1:0] ex_writedata_o,
    output logic [RW-1:0] ex_writereg_o,
    output logic          ex_regwrite_o,
    output logic          ex_memtoreg_o,
    output logic          ex_memwrite_o,
    output logic          ex_valid_o,
    output logic [RW-1:0] ex_rs_o,
    output logic [RW-1:0] ex_rt_o
);

    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic          memwrite_q, memwrite_d;
    logic          alusrc_q, alusrc_d;
    logic          regdst_q, regdst_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] aluc_q, aluc_d;

    // Flush loads an all-zero bubble and overrides stall.
    always_comb begin
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memwrite_d = memwrite_q;
        alusrc_d   = alusrc_q;
        regdst_d   = regdst_q;
        valid_d    = valid_q;
        aluc_d     = aluc_q;
        if (flush_i) begin
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            regdst_d   = 1'b0;
            valid_d    = 1'b0;
            aluc_d     = '0;
        end else if (!stall_i) begin
            rd1_d      = id_rd1_i;
            rd2_d      = id_rd2_i;
            imm_d      = id_signimm_i;
            rs_d       = id_rs_i;
            rt_d       = id_rt_i;
            rd_d       = id_rd_i;
            regwrite_d = id_regwrite_i;
            memtoreg_d = id_memtoreg_i;
            memwrite_d = id_memwrite_i;
            alusrc_d   = id_alusrc_i;
            regdst_d   = id_regdst_i;
            valid_d    = id_valid_i;
            aluc_d     = id_alucontrol_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            regdst_q   <= 1'b0;
            valid_q    <= 1'b0;
            aluc_q     <= '0;
        end else begin
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
            alusrc_q   <= alusrc_d;
            regdst_q   <= regdst_d;
            valid_q    <= valid_d;
            aluc_q     <= aluc_d;
        end
    end

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

`ifdef FORWARD_EN
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    forward_unit #(.RW(RW)) u_fwd_rs (
        .src_i          (rs_q),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_writereg_i (mem_writereg_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .wb_writereg_i  (wb_writereg_i),
        .sel_o          (sel_a)
    );

    forward_unit #(.RW(RW)) u_fwd_rt (
        .src_i          (rt_q),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_writereg_i (mem_writereg_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .wb_writereg_i  (wb_writereg_i),
        .sel_o          (sel_b)
    );

    always_comb begin
        case (sel_a)
            FWD_MEM: fwd_a = mem_aluout_i;
            FWD_WB:  fwd_a = wb_result_i;
            default: fwd_a = rd1_q;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = mem_aluout_i;
            FWD_WB:  fwd_b = wb_result_i;
            default: fwd_b = rd2_q;
        endcase
    end
`else
    // Without forwarding the later-stage results are not consumed here.
    logic unused_fwd_src;
    assign unused_fwd_src = ^{mem_regwrite_i, mem_writereg_i, mem_aluout_i,
                              wb_regwrite_i, wb_writereg_i, wb_result_i};
    assign fwd_a = rd1_q;
    assign fwd_b = rd2_q;
`endif

    assign ex_srca_o       = fwd_a;
    assign ex_writedata_o  = fwd_b;
    assign ex_srcb_o       = alusrc_q ? imm_q : fwd_b;
    assign ex_alucontrol_o = aluc_q;
    assign ex_writereg_o   = regdst_q ? rd_q : rt_q;
    assign ex_regwrite_o   = regwrite_q;
    assign ex_memtoreg_o   = memtoreg_q;
    assign ex_memwrite_o   = memwrite_q;
    assign ex_valid_o      = valid_q;
    assign ex_rs_o         = rs_q;
    assign ex_rt_o         = rt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus random bench for id_ex_stage with a reference model feeding a scoreboard.
// Expectations follow FORWARD_EN so the same bench covers both builds.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_signimm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst;
    logic [2:0]  id_alucontrol;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_writereg, wb_writereg;
    logic [31:0] mem_aluout, wb_result;
    logic [31:0] ex_srca, ex_srcb, ex_writedata;
    logic [2:0]  ex_alucontrol;
    logic [4:0]  ex_writereg, ex_rs, ex_rt;
    logic        ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_rd1_i(id_rd1), .id_rd2_i(id_rd2),
        .id_signimm_i(id_signimm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memtoreg_i(id_memtoreg),
        .id_memwrite_i(id_memwrite), .id_alusrc_i(id_alusrc), .id_regdst_i(id_regdst),
        .id_alucontrol_i(id_alucontrol),
        .mem_regwrite_i(mem_regwrite), .mem_writereg_i(mem_writereg), .mem_aluout_i(mem_aluout),
        .wb_regwrite_i(wb_regwrite), .wb_writereg_i(wb_writereg), .wb_result_i(wb_result),
        .ex_srca_o(ex_srca), .ex_srcb_o(ex_srcb), .ex_alucontrol_o(ex_alucontrol),
        .ex_writedata_o(ex_writedata), .ex_writereg_o(ex_writereg),
        .ex_regwrite_o(ex_regwrite), .ex_memtoreg_o(ex_memtoreg),
        .ex_memwrite_o(ex_memwrite), .ex_valid_o(ex_valid),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt)
    );

    typedef struct {
        logic [31:0] srca, srcb, wdata;
        logic [2:0]  aluc;
        logic [4:0]  wreg, rs, rt;
        logic        rw, m2r, mw, v;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // reference register state
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_rw, m_m2r, m_mw, m_asrc, m_rdst, m_v;
    logic [2:0]  m_aluc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] x, input logic [31:0] regval);
`ifdef FORWARD_EN
        if (mem_regwrite && mem_writereg == x && x != 5'd0) return mem_aluout;
        if (wb_regwrite && wb_writereg == x && x != 5'd0) return wb_result;
`endif
        return regval;
    endfunction

    task automatic model_clock();
        if (!rst_n || flush) begin
            {m_rd1, m_rd2, m_imm} = '0;
            {m_rs, m_rt, m_rd} = '0;
            {m_rw, m_m2r, m_mw, m_asrc, m_rdst, m_v} = '0;
            m_aluc = '0;
        end else if (!stall) begin
            m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_signimm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rw = id_regwrite; m_m2r = id_memtoreg; m_mw = id_memwrite;
            m_asrc = id_alusrc; m_rdst = id_regdst; m_v = id_valid; m_aluc = id_alucontrol;
        end
    endtask

    task automatic check_now();
        exp_t e;
        exp_t g;
        e.srca  = model_fwd(m_rs, m_rd1);
        e.wdata = model_fwd(m_rt, m_rd2);
        e.srcb  = m_asrc ? m_imm : e.wdata;
        e.aluc  = m_aluc;
        e.wreg  = m_rdst ? m_rd : m_rt;
        e.rs = m_rs; e.rt = m_rt;
        e.rw = m_rw; e.m2r = m_m2r; e.mw = m_mw; e.v = m_v;
        sb.push_back(e);
        g = sb.pop_front();
        chk("srca", ex_srca, g.srca);
        chk("srcb", ex_srcb, g.srcb);
        chk("writedata", ex_writedata, g.wdata);
        chk("alucontrol", 32'(ex_alucontrol), 32'(g.aluc));
        chk("writereg", 32'(ex_writereg), 32'(g.wreg));
        chk("rs", 32'(ex_rs), 32'(g.rs));
        chk("rt", 32'(ex_rt), 32'(g.rt));
        chk("ctrl", 32'({ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid}),
            32'({g.rw, g.m2r, g.mw, g.v}));
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic load_id(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] aluc, input logic asrc, input logic rdst,
                           input logic rw, input logic mw);
        id_valid = 1'b1; id_rd1 = a; id_rd2 = b; id_signimm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_alucontrol = aluc;
        id_alusrc = asrc; id_regdst = rdst; id_regwrite = rw; id_memwrite = mw;
        id_memtoreg = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_regwrite = 1'b0; mem_writereg = '0; mem_aluout = '0;
        wb_regwrite = 1'b0; wb_writereg = '0; wb_result = '0;
        id_memtoreg = 1'b1;
        load_id($urandom, $urandom, $urandom, 5'd7, 5'd8, 5'd9, ALUSLT, 1'b1, 1'b1, 1'b1, 1'b1);

        // 1: reset with random ID contents, then first real load
        for (int i = 0; i < 2; i++) begin
            cycle();
            id_rd1 = $urandom; id_rd2 = $urandom; id_signimm = $urandom;
        end
        chk("rst_srca", ex_srca, 32'd0);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        rst_n = 1'b1;
        load_id(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4, ALUADD, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("first_srca", ex_srca, 32'd5);
        chk("first_srcb", ex_srcb, 32'd7);
        chk("first_aluc", 32'(ex_alucontrol), 32'(ALUADD));
        chk("first_wreg", 32'(ex_writereg), 32'd4);

        // 2: EX/MEM forward, and priority over MEM/WB
        load_id(32'h11, 32'h22, 32'd0, 5'd3, 5'd6, 5'd3, ALUSUB, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        mem_regwrite = 1'b1; mem_writereg = 5'd3; mem_aluout = 32'h64;
        #1; check_now();
`ifdef FORWARD_EN
        chk("mem_fwd_srca", ex_srca, 32'h64);
`else
        chk("nofwd_srca", ex_srca, 32'h11);
`endif
        wb_regwrite = 1'b1; wb_writereg = 5'd3; wb_result = 32'h99;
        #1; check_now();
`ifdef FORWARD_EN
        chk("mem_beats_wb", ex_srca, 32'h64);
`endif
        wb_regwrite = 1'b0;

        // 3: register 0 is never forwarded
        load_id(32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd0, ALUOR, 1'b0, 1'b0, 1'b1, 1'b0);
        mem_regwrite = 1'b1; mem_writereg = 5'd0; mem_aluout = 32'hFF;
        cycle();
        chk("r0_srcb", ex_srcb, 32'd0);
        mem_regwrite = 1'b0;

        // 4: stall holds A for three cycles, B appears after release
        load_id(32'hA1, 32'hA2, 32'd0, 5'd10, 5'd11, 5'd12, ALUAND, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        load_id(32'hB1, 32'hB2, 32'd0, 5'd13, 5'd14, 5'd15, ALUOR, 1'b0, 1'b0, 1'b0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold_srca", ex_srca, 32'hA1);
        end
        stall = 1'b0;
        cycle();
        chk("release_srca", ex_srca, 32'hB1);
        chk("release_wreg", 32'(ex_writereg), 32'd14);

        // 5: flush overrides stall
        load_id(32'hC1, 32'hC2, 32'd0, 5'd1, 5'd2, 5'd3, ALUADD, 1'b0, 1'b1, 1'b1, 1'b1);
        stall = 1'b1; flush = 1'b1;
        cycle();
        chk("flush_ctrl", 32'({ex_valid, ex_regwrite, ex_memwrite}), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // 6: store with immediate and rt forwarded from WB
        load_id(32'h40, 32'h55, 32'd8, 5'd4, 5'd9, 5'd0, ALUADD, 1'b1, 1'b0, 1'b0, 1'b1);
        wb_regwrite = 1'b1; wb_writereg = 5'd9; wb_result = 32'h1234;
        cycle();
        chk("store_srcb", ex_srcb, 32'd8);
`ifdef FORWARD_EN
        chk("store_wdata", ex_writedata, 32'h1234);
`else
        chk("store_wdata", ex_writedata, 32'h55);
`endif

        // random traffic over a few indices so forwarding matches are frequent
        for (int i = 0; i < 60; i++) begin
            load_id($urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                    3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            id_valid = 1'($urandom); id_memtoreg = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 19) != 0);
            mem_regwrite = 1'($urandom); mem_writereg = 5'($urandom_range(0, 3));
            mem_aluout = $urandom;
            wb_regwrite = 1'($urandom); wb_writereg = 5'($urandom_range(0, 3));
            wb_result = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
